spi_cfg_ctrl: RTL and testbench
===============================

// Module: spi_cfg_ctrl
// PURPOSE
//  System-clock-domain SPI slave that sequences host config frames into the demoscene control registers.
//  Decodes {cmd/addr, data...} frames. Holds writes in shadow registers. Commits them to the active
//  outputs on the vsync boundary, so the picture never changes mid-frame. Supports readback on MISO.
//  Sits between the top-level SPI pins and the background, colour and audio generators.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth for SCLK/SSEL_N/MOSI (>=2)
//  IMMEDIATE    0  1: shadow->active copy happens on every write, and vsync is ignored
//  NUM_REGS     4  implemented register addresses 0..NUM_REGS-1
// PORTS
//  clk               in   1  system clock; SPI SCLK must be <= clk/8
//  rst               in   1  asynchronous, active-high reset
//  SCLK              in   1  SPI clock, mode 0, MSB first, asynchronous to clk
//  SSEL_N            in   1  SPI select, active low
//  MOSI              in   1  SPI data in
//  MISO              out  1  SPI data out; 0 while deselected
//  vsync             in   1  one-clk pulse at frame start; commit strobe
//  background_state  out  8  active reg 0
//  solid_color       out  6  active reg 1
//  audio_en          out  1  active reg 2
//  cfg_pending       out  1  shadow differs from active (uncommitted write)
// BEHAVIOUR
//  Reset: background_state=0, solid_color=6'b101010, audio_en=1, shadows equal, MISO=0, cfg_pending=0,
//   frame_err=0, FSM=IDLE.
//  Inputs pass through SYNC_STAGES flops. Edges are detected on the synced SCLK. sclk_rise samples
//   MOSI; sclk_fall drives MISO.
//  FSM IDLE -> CMD on synced SSEL_N falling. CMD -> DATA after 8 bits.
//   In DATA, each 8 bits completes one byte; the FSM stays in DATA and the address increments (burst).
//   Any state -> IDLE on synced SSEL_N high.
//  CMD byte = {rw, addr[6:0]}, where rw=1 means read.
//  Write: completed DATA byte -> shadow[addr] 1 clk after the 8th synced rise. Width truncates to the
//   register width (LSBs kept).
//  Read: on the sclk_fall after a byte completes, load tx = reg[addr], the ACTIVE value.
//   MISO = tx[7] and then shifts on each fall, so MISO is valid before the next rise.
//  Reg 3 = status, read-only: {6'b0, frame_err, cfg_pending}. Writes to 3 are dropped.
//   Reading 3 clears frame_err.
//  addr >= NUM_REGS: write dropped, read returns 8'h00. addr increments and saturates at 7'h7F.
//  SSEL_N rising with bit count != 0 (partial byte): byte discarded, frame_err=1 (sticky).
//   Earlier completed bytes remain valid.
//  Commit: on vsync, active <= shadow for regs 0..2, all in the same cycle, and cfg_pending=0.
//  Shadow write and vsync in the same clk: active takes the OLD shadow. The new value stays pending
//   until the next vsync.
//  IMMEDIATE=1: active updates 1 clk after the shadow write.
//  rst mid-frame: everything returns to reset values at once. The frame resumes only after a new
//   SSEL_N falling edge.
//  The SCLK counter resets whenever SSEL_N is high. MISO=0 whenever synced SSEL_N is high.
// STRUCTURE
//  Package spi_cfg_pkg:
//   - ADDR_BG=0, ADDR_COLOR=1, ADDR_AUDIO=2, ADDR_STATUS=3
//   - reset constants BG_RST=8'h00, COLOR_RST=6'b101010, AUDIO_RST=1'b1
//   - FSM enum {IDLE,CMD,DATA}
//  Sub-module spi_sync: N-flop synchroniser plus rise/fall pulse generation for SCLK and SSEL_N,
//   and a synchronised MOSI.
//  Top: FSM, bit counter, rx/tx shifters, shadow and active register banks, commit logic.
// TESTING
//  Write 0x01,0x15 then vsync -> solid_color stays 6'b101010 until vsync, then 6'h15;
//   cfg_pending 1 then 0.
//  Burst 0x00,0xA5,0x3F,0x00 with one vsync -> bg=0xA5, color=0x3F, audio_en=0 all in the same clk.
//  Write reg2 in the same clk as vsync -> audio_en unchanged; changes at the next vsync.
//  Read 0x80 after bg=0xA5 committed -> MISO bits 1,0,1,0,0,1,0,1 on rises 9-16.
//   Read 0x85 -> 0x00.
//  Deselect after 5 bits of a data byte -> no reg change, frame_err=1.
//   Read 0x83 -> 0x02, then 0x83 again -> 0x00.
//  Assert rst mid-burst -> outputs return to 0/6'b101010/1. The next clean frame works.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants, reset values and FSM state type for the SPI configuration controller.
package spi_cfg_pkg;

    localparam logic [6:0] ADDR_BG     = 7'd0;
    localparam logic [6:0] ADDR_COLOR  = 7'd1;
    localparam logic [6:0] ADDR_AUDIO  = 7'd2;
    localparam logic [6:0] ADDR_STATUS = 7'd3;

    localparam logic [7:0] BG_RST    = 8'h00;
    localparam logic [5:0] COLOR_RST = 6'b101010;
    localparam logic       AUDIO_RST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_e;

    // Burst address advance; parks at the top address instead of wrapping.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        return (a == 7'h7F) ? a : a + 7'd1;
    endfunction

endpackage

// File: rtl/spi_cfg_ctrl_sync.sv
// Synchronises the SPI pins into clk and produces single-cycle edge pulses for SCLK and SSEL_N.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic ssel_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ssel_n_o,
    output logic ssel_fall_o,
    output logic ssel_rise_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sclk_q, ssel_q, mosi_q;
    logic                   sclk_prev_q, ssel_prev_q;

    // Select history resets low so a select already held across reset is
    // never mistaken for a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            ssel_q      <= '0;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            ssel_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            ssel_q      <= {ssel_q[SYNC_STAGES-2:0], ssel_n_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            ssel_prev_q <= ssel_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign ssel_n_o    = ssel_q[SYNC_STAGES-1];
    assign ssel_fall_o = ~ssel_q[SYNC_STAGES-1] & ssel_prev_q;
    assign ssel_rise_o = ssel_q[SYNC_STAGES-1] & ~ssel_prev_q;
    assign mosi_o      = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI slave that loads config frames into shadow registers and commits them to the
// active outputs on vsync (or immediately when IMMEDIATE=1), with MISO readback.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IMMEDIATE   = 0,
    parameter int NUM_REGS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       SSEL_N,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       vsync,
    output logic [7:0] background_state,
    output logic [5:0] solid_color,
    output logic       audio_en,
    output logic       cfg_pending
);

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic sclk_rise, sclk_fall, ssel_n_s, ssel_fall, ssel_rise, mosi_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (SCLK),
        .ssel_n_i   (SSEL_N),
        .mosi_i     (MOSI),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .ssel_n_o   (ssel_n_s),
        .ssel_fall_o(ssel_fall),
        .ssel_rise_o(ssel_rise),
        .mosi_o     (mosi_s)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic       load_q, load_d;
    logic       err_q, err_d;
    logic [7:0] sh_bg_q, sh_bg_d, act_bg_q, act_bg_d;
    logic [5:0] sh_col_q, sh_col_d, act_col_q, act_col_d;
    logic       sh_aud_q, sh_aud_d, act_aud_q, act_aud_d;

    logic [7:0] rx_next;
    logic       byte_done, addr_ok, pending;
    logic [7:0] rd_val;

    assign rx_next   = {rx_q, mosi_s};
    assign byte_done = sclk_rise && (state_q != IDLE) && (bit_cnt_q == 3'd7);
    assign addr_ok   = {1'b0, addr_q} < NUM_REGS_W;
    assign pending   = (sh_bg_q != act_bg_q) || (sh_col_q != act_col_q) || (sh_aud_q != act_aud_q);

    always_comb begin
        rd_val = 8'h00;
        if (addr_ok) begin
            case (addr_q)
                ADDR_BG:     rd_val = act_bg_q;
                ADDR_COLOR:  rd_val = {2'b00, act_col_q};
                ADDR_AUDIO:  rd_val = {7'b0, act_aud_q};
                ADDR_STATUS: rd_val = {6'b0, err_q, pending};
                default:     rd_val = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            sh_bg_q   <= BG_RST;
            sh_col_q  <= COLOR_RST;
            sh_aud_q  <= AUDIO_RST;
            act_bg_q  <= BG_RST;
            act_col_q <= COLOR_RST;
            act_aud_q <= AUDIO_RST;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            load_q    <= load_d;
            err_q     <= err_d;
            sh_bg_q   <= sh_bg_d;
            sh_col_q  <= sh_col_d;
            sh_aud_q  <= sh_aud_d;
            act_bg_q  <= act_bg_d;
            act_col_q <= act_col_d;
            act_aud_q <= act_aud_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        load_d    = load_q;
        err_d     = err_q;
        sh_bg_d   = sh_bg_q;
        sh_col_d  = sh_col_q;
        sh_aud_d  = sh_aud_q;
        act_bg_d  = act_bg_q;
        act_col_d = act_col_q;
        act_aud_d = act_aud_q;

        // Commit reads the registered shadow, so a write landing in the vsync cycle waits a frame.
        if ((IMMEDIATE != 0) || vsync) begin
            act_bg_d  = sh_bg_q;
            act_col_d = sh_col_q;
            act_aud_d = sh_aud_q;
        end

        if (state_q != IDLE) begin
            if (sclk_rise) begin
                rx_d      = rx_next[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sclk_fall) begin
                if (load_q) begin
                    load_d = 1'b0;
                    tx_d   = rw_q ? rd_val : 8'h00;
                    if (rw_q && addr_ok && (addr_q == ADDR_STATUS))
                        err_d = 1'b0;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end

        case (state_q)
            IDLE: if (ssel_fall) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    state_d = DATA;
                    addr_d  = rx_next[6:0];
                    rw_d    = rx_next[7];
                    load_d  = 1'b1;
                end
            end
            DATA: begin
                if (byte_done) begin
                    load_d = 1'b1;
                    addr_d = addr_inc(addr_q);
                    if (!rw_q && addr_ok) begin
                        case (addr_q)
                            ADDR_BG:    sh_bg_d  = rx_next;
                            ADDR_COLOR: sh_col_d = rx_next[5:0];
                            ADDR_AUDIO: sh_aud_d = rx_next[0];
                            default:    ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ssel_n_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_d      = 8'h00;
            load_d    = 1'b0;
            if (ssel_rise && (state_q != IDLE) && (bit_cnt_q != 3'd0))
                err_d = 1'b1;
        end
    end

    assign MISO             = ssel_n_s ? 1'b0 : tx_q[7];
    assign background_state = act_bg_q;
    assign solid_color      = act_col_q;
    assign audio_en         = act_aud_q;
    assign cfg_pending      = pending;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Bench for spi_cfg_ctrl: table of single-register writes with commit and readback,
// plus hand sequences for burst commit, vsync collision, partial bytes and mid-frame reset.
module tb_spi_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0, SSEL_N = 1'b1, MOSI = 1'b0, vsync = 1'b0;
    logic       MISO, audio_en, cfg_pending;
    logic [7:0] background_state;
    logic [5:0] solid_color;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cur_bg  = 8'h00;
    logic [5:0] cur_col = 6'b101010;
    logic       cur_aud = 1'b1;

    spi_cfg_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .SCLK            (SCLK),
        .SSEL_N          (SSEL_N),
        .MOSI            (MOSI),
        .MISO            (MISO),
        .vsync           (vsync),
        .background_state(background_state),
        .solid_color     (solid_color),
        .audio_en        (audio_en),
        .cfg_pending     (cfg_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] bg;
        logic [5:0] col;
        logic       aud;
        logic [7:0] rdback;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [7:0] bg, input logic [5:0] col, input logic aud);
        chk({name, " bg"}, 32'(background_state), 32'(bg));
        chk({name, " col"}, 32'(solid_color), 32'(col));
        chk({name, " aud"}, 32'(audio_en), 32'(aud));
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, input bit vs_last, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            repeat (4) @(negedge clk);
            r[7-i] = MISO;
            SCLK = 1'b1;
            // Two syncs plus one edge-detect cycle place the shadow write on the 3rd clk after this edge.
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                vsync = vs_last && (i == nbits - 1) && (k == 2);
            end
            SCLK = 1'b0;
        end
    endtask

    task automatic sel();
        SSEL_N = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic desel();
        repeat (4) @(negedge clk);
        SSEL_N = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        sel();
        xfer(a, 8, 1'b0, r);
        xfer(d, 8, 1'b0, r);
        desel();
    endtask

    task automatic rd_check(input string name, input logic [6:0] a, output logic [7:0] v);
        logic [7:0] r;
        sel();
        xfer({1'b1, a}, 8, 1'b0, r);
        xfer(8'h00, 8, 1'b0, v);
        desel();
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %0h", name, v);
        end else begin
            chk(name, 32'(v), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t       vecs[7];
    logic [7:0] v, r;
    logic       exp_pend;

    initial begin
        vecs[0] = '{8'h01, 8'h15, 8'h00, 6'h15, 1'b1, 8'h15};
        vecs[1] = '{8'h00, 8'h3C, 8'h3C, 6'h15, 1'b1, 8'h3C};
        vecs[2] = '{8'h01, 8'hFF, 8'h3C, 6'h3F, 1'b1, 8'h3F};
        vecs[3] = '{8'h02, 8'hFE, 8'h3C, 6'h3F, 1'b0, 8'h00};
        vecs[4] = '{8'h03, 8'hFF, 8'h3C, 6'h3F, 1'b0, 8'h00};
        vecs[5] = '{8'h05, 8'h77, 8'h3C, 6'h3F, 1'b0, 8'h00};
        vecs[6] = '{8'h02, 8'h01, 8'h3C, 6'h3F, 1'b1, 8'h01};

        repeat (3) @(negedge clk);
        chk_outs("reset", 8'h00, 6'b101010, 1'b1);
        chk("reset miso", 32'(MISO), 32'd0);
        chk("reset pending", 32'(cfg_pending), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int n = 0; n < 7; n++) begin
            wr(vecs[n].cmd, vecs[n].data);
            exp_pend = (vecs[n].bg != cur_bg) || (vecs[n].col != cur_col) || (vecs[n].aud != cur_aud);
            chk($sformatf("vec%0d pending", n), 32'(cfg_pending), 32'(exp_pend));
            chk_outs($sformatf("vec%0d pre", n), cur_bg, cur_col, cur_aud);
            pulse_vsync();
            chk_outs($sformatf("vec%0d post", n), vecs[n].bg, vecs[n].col, vecs[n].aud);
            chk($sformatf("vec%0d pending clr", n), 32'(cfg_pending), 32'd0);
            cur_bg  = vecs[n].bg;
            cur_col = vecs[n].col;
            cur_aud = vecs[n].aud;
            exp_q.push_back(vecs[n].rdback);
            rd_check($sformatf("vec%0d readback", n), vecs[n].cmd[6:0], v);
        end

        // Burst of three writes committed together by a single vsync.
        sel();
        xfer(8'h00, 8, 1'b0, r);
        xfer(8'hA5, 8, 1'b0, r);
        xfer(8'h3F, 8, 1'b0, r);
        xfer(8'h00, 8, 1'b0, r);
        desel();
        chk("burst pending", 32'(cfg_pending), 32'd1);
        @(negedge clk);
        chk_outs("burst pre", 8'h3C, 6'h3F, 1'b1);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk_outs("burst post", 8'hA5, 6'h3F, 1'b0);
        chk("burst pending clr", 32'(cfg_pending), 32'd0);
        repeat (2) @(negedge clk);

        exp_q.push_back(8'hA5);
        rd_check("read bg", 7'h00, v);
        for (int b = 0; b < 8; b++) begin
            r = 8'hA5;
            chk($sformatf("read bg rise%0d", 9 + b), 32'(v[7-b]), 32'(r[7-b]));
        end
        exp_q.push_back(8'h00);
        rd_check("read unimpl 5", 7'h05, v);

        // Write to reg2 lands in the same clk as vsync; commit takes the old shadow.
        sel();
        xfer(8'h02, 8, 1'b0, r);
        xfer(8'h01, 8, 1'b1, r);
        desel();
        chk("collide aud held", 32'(audio_en), 32'd0);
        chk("collide pending", 32'(cfg_pending), 32'd1);
        pulse_vsync();
        chk("collide aud next", 32'(audio_en), 32'd1);
        chk("collide pending clr", 32'(cfg_pending), 32'd0);

        // Partial data byte then deselect.
        sel();
        xfer(8'h00, 8, 1'b0, r);
        xfer(8'hFF, 5, 1'b0, r);
        desel();
        chk("partial pending", 32'(cfg_pending), 32'd0);
        pulse_vsync();
        chk("partial bg kept", 32'(background_state), 32'hA5);
        exp_q.push_back(8'h02);
        rd_check("status err set", 7'h03, v);
        exp_q.push_back(8'h00);
        rd_check("status err clr", 7'h03, v);

        // Reset in the middle of a burst; select stays low across the reset.
        sel();
        xfer(8'h00, 8, 1'b0, r);
        xfer(8'h11, 8, 1'b0, r);
        xfer(8'h22, 3, 1'b0, r);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs("rst mid", 8'h00, 6'b101010, 1'b1);
        chk("rst mid pending", 32'(cfg_pending), 32'd0);
        chk("rst mid miso", 32'(MISO), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xfer(8'h5A, 5, 1'b0, r);
        xfer(8'h33, 8, 1'b0, r);
        desel();
        pulse_vsync();
        chk_outs("rst garbage ignored", 8'h00, 6'b101010, 1'b1);
        wr(8'h00, 8'h99);
        pulse_vsync();
        chk("rst clean frame", 32'(background_state), 32'h99);
        exp_q.push_back(8'h00);
        rd_check("rst status", 7'h03, v);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
